// File: rtl/float_to_int_converter_if.sv
// Handshake and data bundle between a float producer, the float-to-int
// converter and its integer consumer.
interface float_to_int_converter_if #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int INT_WIDTH      = 32
);
    logic                                     in_valid;
    logic                                     in_ready;
    logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   a;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [INT_WIDTH-1:0]                     out;
    logic                                     overflow_flag;
    logic                                     invalid_operation_flag;
    logic                                     inexact_flag;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, out, overflow_flag, invalid_operation_flag, inexact_flag
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, out, overflow_flag, invalid_operation_flag, inexact_flag
    );
endinterface

// File: rtl/float_to_int_converter.sv
// Multi-cycle float -> signed integer converter: unpack, iterative align, round, saturate.
// Define FLOAT_TO_INT_FAST_SHIFT_EN to replace the bit-serial aligner with a one-cycle barrel shifter.
module float_to_int_converter #(
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int INT_WIDTH        = 32,
    parameter int ROUND_TO_NEAREST = 1
) (
    input logic                     clk,
    input logic                     rst,
    float_to_int_converter_if.slave bus_io
);
    localparam int W     = (INT_WIDTH > MANTISSA_WIDTH + 1) ? INT_WIDTH : MANTISSA_WIDTH + 1;
    localparam int CNT_W = $clog2(W + 3);
    localparam int BIAS  = (2 ** (EXPONENT_WIDTH - 1)) - 1;

    localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic [W:0]           MIN_MAG = (W+1)'(1) << (INT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         mag_q, mag_d;
    logic                 guard_q, guard_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 left_q, left_d;
    logic                 sign_q, sign_d;
    logic [INT_WIDTH-1:0] out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic                 inv_q, inv_d;
    logic                 inx_q, inx_d;

    logic                      sign_f;
    logic [EXPONENT_WIDTH-1:0] exp_f;
    logic [MANTISSA_WIDTH-1:0] mant_f;
    int                        unb_exp;
    int                        shamt;
    logic                      shift_left;
    logic                      round_up;
    logic [W:0]                rounded;
    logic [INT_WIDTH-1:0]      rnd_low;
`ifdef FLOAT_TO_INT_FAST_SHIFT_EN
    logic [2*W-1:0]            wide;
`endif

    assign sign_f = bus_io.a[EXPONENT_WIDTH+MANTISSA_WIDTH];
    assign exp_f  = bus_io.a[MANTISSA_WIDTH +: EXPONENT_WIDTH];
    assign mant_f = bus_io.a[MANTISSA_WIDTH-1:0];

    // Alignment direction and distance; right shifts past guard+1 only feed sticky, so cap them.
    always_comb begin
        unb_exp    = int'(exp_f) - BIAS;
        shift_left = 1'b0;
        shamt      = 0;
        if (unb_exp >= MANTISSA_WIDTH) begin
            shift_left = 1'b1;
            shamt      = unb_exp - MANTISSA_WIDTH;
        end else begin
            shamt = MANTISSA_WIDTH - unb_exp;
            if (shamt > MANTISSA_WIDTH + 2) begin
                shamt = MANTISSA_WIDTH + 2;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        sign_d   = sign_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        inx_d    = inx_q;
        round_up = (ROUND_TO_NEAREST != 0) && guard_q && (sticky_q || mag_q[0]);
        rounded  = {1'b0, mag_q} + (W+1)'(round_up);
        rnd_low  = rounded[INT_WIDTH-1:0];
`ifdef FLOAT_TO_INT_FAST_SHIFT_EN
        wide     = {mag_q, {W{1'b0}}} >> cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus_io.in_valid) begin
                    sign_d = sign_f;
                    out_d  = '0;
                    ovf_d  = 1'b0;
                    inv_d  = 1'b0;
                    inx_d  = 1'b0;
                    if (exp_f == '1) begin
                        state_d = DONE;
                        if (mant_f != '0) begin
                            inv_d = 1'b1;
                        end else begin
                            out_d = sign_f ? INT_MIN : INT_MAX;
                            ovf_d = 1'b1;
                        end
                    end else if (exp_f == '0) begin
                        state_d = DONE;
                        inx_d   = (mant_f != '0);
                    end else if (unb_exp >= INT_WIDTH - 1) begin
                        state_d = DONE;
                        // -2^(INT_WIDTH-1) itself is representable.
                        if (sign_f && (unb_exp == INT_WIDTH - 1) && (mant_f == '0)) begin
                            out_d = INT_MIN;
                        end else begin
                            out_d = sign_f ? INT_MIN : INT_MAX;
                            ovf_d = 1'b1;
                        end
                    end else begin
                        mag_d    = W'({1'b1, mant_f});
                        guard_d  = 1'b0;
                        sticky_d = 1'b0;
                        left_d   = shift_left;
                        cnt_d    = CNT_W'(shamt);
                        state_d  = (shamt == 0) ? ROUND : SHIFT;
                    end
                end
            end

            SHIFT: begin
`ifdef FLOAT_TO_INT_FAST_SHIFT_EN
                if (left_q) begin
                    mag_d = mag_q << cnt_q;
                end else begin
                    mag_d    = wide[2*W-1:W];
                    guard_d  = wide[W-1];
                    sticky_d = |wide[W-2:0];
                end
                state_d = ROUND;
`else
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d    = mag_q >> 1;
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ROUND;
                end
`endif
            end

            ROUND: begin
                inx_d   = guard_q | sticky_q;
                state_d = DONE;
                if (rounded >= MIN_MAG) begin
                    if (sign_q && (rounded == MIN_MAG)) begin
                        out_d = INT_MIN;
                    end else begin
                        out_d = sign_q ? INT_MIN : INT_MAX;
                        ovf_d = 1'b1;
                    end
                end else begin
                    out_d = sign_q ? (~rnd_low + INT_WIDTH'(1)) : rnd_low;
                end
            end

            DONE: begin
                if (bus_io.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            sign_q   <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            sign_q   <= sign_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
            inx_q    <= inx_d;
        end
    end

    assign bus_io.in_ready               = (state_q == IDLE);
    assign bus_io.out_valid              = (state_q == DONE);
    assign bus_io.out                    = out_q;
    assign bus_io.overflow_flag          = ovf_q;
    assign bus_io.invalid_operation_flag = inv_q;
    assign bus_io.inexact_flag           = inx_q;
endmodule

// File: tb/tb_float_to_int_converter.sv
// Directed-vector bench for float_to_int_converter (E8M23 -> int32), with a
// second truncating instance fed from the same stimulus.
module tb_float_to_int_converter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_in = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] r_out;
    logic [2:0]  r_flags;
    int          r_lat;
    logic [31:0] t_out;
    logic        t_inx;

    float_to_int_converter_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .INT_WIDTH(32)) bus ();
    float_to_int_converter_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .INT_WIDTH(32)) tbus ();

    assign bus.in_valid   = in_valid;
    assign bus.a          = a_in;
    assign bus.out_ready  = out_ready;
    assign tbus.in_valid  = in_valid;
    assign tbus.a         = a_in;
    assign tbus.out_ready = out_ready;

    float_to_int_converter #(
        .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .INT_WIDTH(32), .ROUND_TO_NEAREST(1)
    ) dut (
        .clk(clk), .rst(rst), .bus_io(bus.slave)
    );

    float_to_int_converter #(
        .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .INT_WIDTH(32), .ROUND_TO_NEAREST(0)
    ) dut_trunc (
        .clk(clk), .rst(rst), .bus_io(tbus.slave)
    );

    always #5 clk = ~clk;

    // n < 0 marks a special operand that skips alignment and rounding.
    function automatic int exp_lat(input int n);
        if (n < 0) return 1;
`ifdef FLOAT_TO_INT_FAST_SHIFT_EN
        return (n == 0) ? 2 : 3;
`else
        return n + 2;
`endif
    endfunction

    function automatic logic [2:0] main_flags();
        return {bus.overflow_flag, bus.invalid_operation_flag, bus.inexact_flag};
    endfunction

    task automatic wait_valid();
        r_lat = 1;
        while (!bus.out_valid && r_lat < 200) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("[TB] FAIL timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, r_lat);
        end
    endtask

    task automatic run_conv(input logic [31:0] val);
        int waited;
        @(negedge clk);
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b1;
        a_in     = val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid();
        r_out   = bus.out;
        r_flags = main_flags();
        t_out   = tbus.out;
        t_inx   = tbus.inexact_flag;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b required 0", bus.out_valid);
        end
        checks++;
        if (bus.out !== 32'h0 || main_flags() !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_out_flags: got %h/%b required 00000000/000", bus.out, main_flags());
        end
        rst = 1'b0;
    endtask

    task automatic test_regular();
        logic [31:0] va, eo;
        logic [2:0]  ef;
        int          en;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin va = 32'h3F800000; eo = 32'h00000001; ef = 3'b000; en = 23; end
                1: begin va = 32'h42F60000; eo = 32'd123;      ef = 3'b000; en = 17; end
                2: begin va = 32'hC2F60000; eo = 32'hFFFFFF85; ef = 3'b000; en = 17; end
                3: begin va = 32'h4B800000; eo = 32'h01000000; ef = 3'b000; en = 1;  end
                4: begin va = 32'h4EFFFFFF; eo = 32'h7FFFFF80; ef = 3'b000; en = 7;  end
                default: begin va = 32'hCEFFFFFF; eo = 32'h80000080; ef = 3'b000; en = 7; end
            endcase
            run_conv(va);
            checks++;
            if (r_out !== eo) begin
                errors++;
                $display("[TB] FAIL regular_out a=%h: got %h required %h", va, r_out, eo);
            end
            checks++;
            if (r_flags !== ef) begin
                errors++;
                $display("[TB] FAIL regular_flags a=%h: got %b required %b", va, r_flags, ef);
            end
            checks++;
            if (r_lat != exp_lat(en)) begin
                errors++;
                $display("[TB] FAIL regular_latency a=%h: got %0d required %0d", va, r_lat, exp_lat(en));
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] va, eo;
        logic [2:0]  ef;
        int          en;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin va = 32'h40200000; eo = 32'h00000002; ef = 3'b001; en = 22; end
                1: begin va = 32'hC0600000; eo = 32'hFFFFFFFC; ef = 3'b001; en = 22; end
                2: begin va = 32'h3F000000; eo = 32'h00000000; ef = 3'b001; en = 24; end
                3: begin va = 32'h3FC00000; eo = 32'h00000002; ef = 3'b001; en = 23; end
                4: begin va = 32'h3F400000; eo = 32'h00000001; ef = 3'b001; en = 24; end
                5: begin va = 32'h3FA00000; eo = 32'h00000001; ef = 3'b001; en = 23; end
                6: begin va = 32'h00800000; eo = 32'h00000000; ef = 3'b001; en = 25; end
                7: begin va = 32'h00000001; eo = 32'h00000000; ef = 3'b001; en = -1; end
                default: begin va = 32'h80000000; eo = 32'h00000000; ef = 3'b000; en = -1; end
            endcase
            run_conv(va);
            checks++;
            if (r_out !== eo || r_flags !== ef) begin
                errors++;
                $display("[TB] FAIL rounding a=%h: got %h/%b required %h/%b", va, r_out, r_flags, eo, ef);
            end
            checks++;
            if (r_lat != exp_lat(en)) begin
                errors++;
                $display("[TB] FAIL rounding_latency a=%h: got %0d required %0d", va, r_lat, exp_lat(en));
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va, eo;
        logic [2:0]  ef;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin va = 32'h4F000000; eo = 32'h7FFFFFFF; ef = 3'b100; end
                1: begin va = 32'hCF000000; eo = 32'h80000000; ef = 3'b000; end
                2: begin va = 32'hCF000001; eo = 32'h80000000; ef = 3'b100; end
                3: begin va = 32'h7FC00000; eo = 32'h00000000; ef = 3'b010; end
                4: begin va = 32'h7F800001; eo = 32'h00000000; ef = 3'b010; end
                5: begin va = 32'hFF800000; eo = 32'h80000000; ef = 3'b100; end
                6: begin va = 32'h7F800000; eo = 32'h7FFFFFFF; ef = 3'b100; end
                default: begin va = 32'h5F000000; eo = 32'h7FFFFFFF; ef = 3'b100; end
            endcase
            run_conv(va);
            checks++;
            if (r_out !== eo || r_flags !== ef) begin
                errors++;
                $display("[TB] FAIL special a=%h: got %h/%b required %h/%b", va, r_out, r_flags, eo, ef);
            end
            checks++;
            if (r_lat != 1) begin
                errors++;
                $display("[TB] FAIL special_latency a=%h: got %0d required 1", va, r_lat);
            end
        end
    endtask

    task automatic test_truncate();
        logic [31:0] va, eo;
        logic        ei;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin va = 32'hC0600000; eo = 32'hFFFFFFFD; ei = 1'b1; end
                1: begin va = 32'h3FC00000; eo = 32'h00000001; ei = 1'b1; end
                2: begin va = 32'h40200000; eo = 32'h00000002; ei = 1'b1; end
                3: begin va = 32'h3F400000; eo = 32'h00000000; ei = 1'b1; end
                default: begin va = 32'h4EFFFFFF; eo = 32'h7FFFFF80; ei = 1'b0; end
            endcase
            run_conv(va);
            checks++;
            if (t_out !== eo || t_inx !== ei) begin
                errors++;
                $display("[TB] FAIL truncate a=%h: got %h/inx=%b required %h/inx=%b", va, t_out, t_inx, eo, ei);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 32'hC2F60000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid();
        checks++;
        if (r_lat != exp_lat(17)) begin
            errors++;
            $display("[TB] FAIL backpressure_latency: got %0d required %0d", r_lat, exp_lat(17));
        end
        // A fresh operand offered while a result is pending must be ignored.
        in_valid = 1'b1;
        a_in     = 32'h3F800000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out, main_flags()} !== {1'b1, 1'b0, 32'hFFFFFF85, 3'b000}) begin
                errors++;
                $display("[TB] FAIL hold cycle %0d: got valid=%b ready=%b out=%h flags=%b required 1/0/ffffff85/000",
                         k, bus.out_valid, bus.in_ready, bus.out, main_flags());
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release: got valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 32'h40200000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid();
        checks++;
        if (bus.out !== 32'h2 || main_flags() !== 3'b001) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %h/%b required 00000002/001", bus.out, main_flags());
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = 32'h4B800000;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_overlap: got ready=%b valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid();
        checks++;
        if (bus.out !== 32'h01000000 || main_flags() !== 3'b000 || r_lat != exp_lat(1)) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %h/%b lat=%0d required 01000000/000 lat=%0d",
                     bus.out, main_flags(), r_lat, exp_lat(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 32'h3F800000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 32'h0 || main_flags() !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%b ready=%b out=%h flags=%b required 0/1/00000000/000",
                     bus.out_valid, bus.in_ready, bus.out, main_flags());
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_dropped: out_valid seen=%b required 0", seen);
        end
        run_conv(32'h40200000);
        checks++;
        if (r_out !== 32'h2 || r_flags !== 3'b001) begin
            errors++;
            $display("[TB] FAIL after_reset: got %h/%b required 00000002/001", r_out, r_flags);
        end
    endtask

    initial begin
        test_reset();
        test_regular();
        test_rounding();
        test_specials();
        test_truncate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
